// File: rtl/guess_compare_display.sv
// Result-display stage of the guessing game: on each rising guess strobe, compare the
// guess with the target and latch U / d / C / E onto one 7-segment digit ({g,f,e,d,c,b,a}).
module guess_compare_display #(
  parameter int MAX_VALUE  = 99,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       guess_trigger,
  input  logic [6:0] user_number,
  input  logic [6:0] actual_number,
  output logic [6:0] seg_display
);

  localparam logic [6:0] SEG_BLANK   = 7'b0000000;
  localparam logic [6:0] SEG_UP      = 7'b0111110;
  localparam logic [6:0] SEG_DOWN    = 7'b1011110;
  localparam logic [6:0] SEG_CORRECT = 7'b0111001;
  localparam logic [6:0] SEG_ERROR   = 7'b1111001;

  // One extra bit so MAX_VALUE up to 255 compares without truncation.
  localparam logic [7:0] MAXV = 8'(MAX_VALUE);

  localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic       trig_prev_q;
  logic [6:0] seg_q, seg_d;
  logic       guess_evt;
  logic       out_of_range;
  logic [6:0] result_pat;

  assign guess_evt    = guess_trigger & ~trig_prev_q;
  assign out_of_range = ({1'b0, user_number} > MAXV) || ({1'b0, actual_number} > MAXV);

  always_comb begin
    result_pat = SEG_DOWN;
    if (out_of_range)                      result_pat = SEG_ERROR;
    else if (user_number == actual_number) result_pat = SEG_CORRECT;
    else if (user_number <  actual_number) result_pat = SEG_UP;
  end

  // Polarity is folded in right at the register input, so held values and the
  // reset value are already in pin polarity.
  always_comb begin
    seg_d = seg_q;
    if (guess_evt) seg_d = result_pat ^ POL_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_prev_q <= 1'b0;
      seg_q       <= SEG_BLANK ^ POL_MASK;
    end else begin
      trig_prev_q <= guess_trigger;
      seg_q       <= seg_d;
    end
  end

  assign seg_display = seg_q;

endmodule

// File: tb/tb_guess_compare_display.sv
// Scoreboard bench: a rule-level model predicts the digit after every edge for an
// active-high and an active-low build; a monitor pops and compares after each edge.
module tb_guess_compare_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       guess_trigger = 1'b0;
  logic [6:0] user_number = '0;
  logic [6:0] actual_number = '0;
  logic [6:0] seg_hi, seg_lo;

  always #5 clk = ~clk;

  guess_compare_display #(.MAX_VALUE(99), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .guess_trigger(guess_trigger),
    .user_number(user_number), .actual_number(actual_number), .seg_display(seg_hi));

  guess_compare_display #(.MAX_VALUE(99), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .guess_trigger(guess_trigger),
    .user_number(user_number), .actual_number(actual_number), .seg_display(seg_lo));

  typedef struct {
    logic [6:0] hi;
    logic [6:0] lo;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: what the display should show and the previous trigger level.
  logic [6:0] m_disp = 7'b0000000;
  bit         m_prev = 1'b0;

  function automatic logic [6:0] judge(int u, int a);
    if (u > 99 || a > 99) return 7'b1111001;
    if (u == a)           return 7'b0111001;
    if (u < a)            return 7'b0111110;
    return 7'b1011110;
  endfunction

  task automatic step(input bit rst, input bit trig, input int u, input int a, input string tag);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    guess_trigger = trig;
    user_number   = 7'(u);
    actual_number = 7'(a);
    if (rst) begin
      m_disp = 7'b0000000;
      m_prev = 1'b0;
    end else begin
      if (trig && !m_prev) m_disp = judge(u, a);
      m_prev = trig;
    end
    e.hi  = m_disp;
    e.lo  = ~m_disp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: the digit is always presented, so every edge after stimulus has a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (seg_hi !== e.hi) begin
          n_fail++;
          $display("FAIL %s active-high: got %b expected %b", e.tag, seg_hi, e.hi);
        end
        n_checks++;
        if (seg_lo !== e.lo) begin
          n_fail++;
          $display("FAIL %s active-low: got %b expected %b", e.tag, seg_lo, e.lo);
        end
      end
    end
  end

  function automatic int pick_val();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0: return 99;
      1: return 100;
      2: return 127;
      3: return 0;
      default: return int'($urandom_range(0, 110));
    endcase
  endfunction

  initial begin
    int u, a, wait_cnt;
    bit t, r;

    // Reset held, trigger low, then idle after release: stays blank.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 42, "reset_hold");
    for (int i = 0; i < 3; i++)  step(0, 0, 0, 42, "idle_after_reset");

    // Correct, then hold through trigger drop and an unstrobed input change.
    step(0, 1, 42, 42, "pulse_correct");
    step(0, 0, 42, 42, "hold_correct");
    step(0, 0, 85, 42, "hold_no_trigger");
    step(0, 0, 85, 42, "hold_no_trigger2");

    // Down, up, up again.
    step(0, 1, 85, 42, "pulse_down");
    step(0, 0, 85, 42, "hold_down");
    step(0, 1, 1, 42, "pulse_up");
    step(0, 0, 1, 42, "hold_up");
    step(0, 1, 13, 42, "pulse_up_again");
    step(0, 0, 13, 42, "hold_up_again");

    // Set display to d, then a 5-cycle held trigger: one evaluation of 10 only.
    step(0, 1, 85, 42, "pre_held_down");
    step(0, 0, 85, 42, "pre_held_gap");
    step(0, 1, 10, 42, "held_c1");
    step(0, 1, 10, 42, "held_c2");
    step(0, 1, 50, 42, "held_c3");
    step(0, 1, 50, 42, "held_c4");
    step(0, 1, 50, 42, "held_c5");
    step(0, 0, 50, 42, "held_release");

    // Range boundaries.
    step(0, 1, 100, 42, "err_user_100");
    step(0, 0, 100, 42, "gap");
    step(0, 1, 99, 99, "ok_99_99");
    step(0, 0, 99, 99, "gap");
    step(0, 1, 5, 120, "err_actual_120");
    step(0, 0, 5, 120, "gap");
    step(0, 1, 0, 0, "ok_0_0");
    step(0, 0, 0, 0, "gap");
    step(0, 1, 127, 3, "err_user_127");
    step(0, 0, 127, 3, "gap");
    step(0, 1, 99, 100, "err_actual_100");
    step(0, 0, 99, 100, "gap");
    step(0, 1, 99, 98, "down_99_98");
    step(0, 0, 99, 98, "gap");

    // Mid-display reset, and reset coinciding with a trigger rise.
    step(0, 1, 42, 42, "pre_reset_correct");
    step(0, 0, 42, 42, "pre_reset_hold");
    step(1, 0, 42, 42, "mid_display_reset");
    step(0, 0, 42, 42, "after_reset_blank");
    step(1, 1, 42, 42, "reset_with_trigger");
    step(0, 0, 42, 42, "event_lost");
    step(0, 0, 85, 42, "still_blank");

    // Trigger high across reset release counts as an event (trig_prev cleared).
    step(1, 1, 85, 42, "reset_trig_high");
    step(0, 1, 85, 42, "first_edge_event");
    step(0, 0, 85, 42, "gap");

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 49) == 0);
      t = ($urandom_range(0, 2) == 0);
      u = pick_val();
      a = (($urandom_range(0, 3) == 0) ? u : pick_val());
      step(r, t, u, a, "random");
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
